// File: rtl/framebuffer_writer_pkg.sv
// Shared definitions for the framebuffer write path and the VGA scan-out reader.
//   Screen geometry, pixel field widths, writer FSM state encoding and the
//   (x,y) -> linear framebuffer address mapping.
package framebuffer_writer_pkg;

  localparam int FB_SCR_W   = 320;
  localparam int FB_SCR_H   = 240;
  localparam int FB_ADDR_W  = 17;
  localparam int FB_COLOR_W = 12;
  localparam int FB_X_W     = 9;
  localparam int FB_Y_W     = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } fbw_state_t;

  // addr = y*320 + x built from shifts: y*320 = (y<<8) + (y<<6).
  function automatic logic [FB_ADDR_W-1:0] xy_to_addr(input logic [FB_X_W-1:0] x,
                                                       input logic [FB_Y_W-1:0] y);
    logic [FB_ADDR_W-1:0] yw;
    yw = FB_ADDR_W'(y);
    return (yw << 8) + (yw << 6) + FB_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/framebuffer_writer_pixel_fifo.sv
// pixel_fifo: small synchronous FIFO holding {addr, color} pixel words.
//   clock, resetn : clock and asynchronous active-low reset
//   push, din     : write request and data (ignored while full)
//   pop, dout     : read request and head-of-queue data (dout valid while !empty)
//   full, empty   : flags decoded from a registered occupancy count
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 29
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/framebuffer_writer.sv
// framebuffer_writer: sink of the draw-FSM pixel stream. Clips, buffers and
// writes pixels to the framebuffer RAM write port; also sweeps a clear colour
// over the whole screen on request.
//   clock, resetn           : clock, asynchronous active-low reset
//   pix_x/pix_y/pix_color   : pixel coordinates and RGB 4:4:4 colour
//   pix_we, pix_ready       : pixel valid / writer can accept
//   clear_start/clear_color : clear request and its colour
//   clear_busy, clear_done  : clear in progress / one-cycle completion pulse
//   fb_addr/fb_data/fb_we   : registered RAM write port
//   drop_count              : saturating count of clipped pixels
//   overflow                : sticky, pixel offered while not ready
//
// state | meaning
// RUN   | accept pixels, write them out one per cycle
// DRAIN | clear requested; no new pixels, flush queued pixels to RAM
// CLEAR | sweep clear colour over every address 0..SCR_W*SCR_H-1
// DONE  | pulse clear_done, return to RUN
module framebuffer_writer
  import framebuffer_writer_pkg::*;
#(
  parameter int SCR_W      = FB_SCR_W,
  parameter int SCR_H      = FB_SCR_H,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = FB_ADDR_W
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [FB_X_W-1:0]     pix_x,
  input  logic [FB_Y_W-1:0]     pix_y,
  input  logic [FB_COLOR_W-1:0] pix_color,
  input  logic                  pix_we,
  output logic                  pix_ready,
  input  logic                  clear_start,
  input  logic [FB_COLOR_W-1:0] clear_color,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic [ADDR_W-1:0]     fb_addr,
  output logic [FB_COLOR_W-1:0] fb_data,
  output logic                  fb_we,
  output logic [15:0]           drop_count,
  output logic                  overflow
);

  localparam logic [FB_X_W-1:0] X_LIM     = FB_X_W'(SCR_W);
  localparam logic [FB_Y_W-1:0] Y_LIM     = FB_Y_W'(SCR_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCR_W * SCR_H - 1);
  localparam int                PW        = ADDR_W + FB_COLOR_W;

  fbw_state_t state, state_nxt;

  logic                  accept;
  logic                  in_range;
  logic                  push;
  logic                  pop;
  logic [ADDR_W-1:0]     push_addr;
  logic [PW-1:0]         fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ADDR_W-1:0]     sweep_addr;
  logic [FB_COLOR_W-1:0] clear_color_q;

  // Ready comes only from registered state and count, so there is no
  // combinational ready->pop path; a full FIFO refuses even if it pops.
  // Gated by resetn so the output is low while reset is held.
  assign pix_ready  = resetn && (state == ST_RUN) && !fifo_full;
  assign accept     = pix_we && pix_ready;
  assign in_range   = (pix_x < X_LIM) && (pix_y < Y_LIM);
  assign push       = accept && in_range;
  assign clear_busy = (state == ST_DRAIN) || (state == ST_CLEAR);
  assign clear_done = (state == ST_DONE);

  always_comb begin
    push_addr = '0;
    if (SCR_W == FB_SCR_W) push_addr = ADDR_W'(xy_to_addr(pix_x, pix_y));
    else                   push_addr = ADDR_W'(32'(pix_y) * 32'(SCR_W) + 32'(pix_x));
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PW)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .din    ({push_addr, pix_color}),
    .pop    (pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_RUN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_RUN: begin
        pop = !fifo_empty;
        if (clear_start) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) state_nxt = ST_CLEAR;
        else            pop       = 1'b1;
      end
      ST_CLEAR: begin
        if (sweep_addr == LAST_ADDR) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fb_addr       <= '0;
      fb_data       <= '0;
      fb_we         <= 1'b0;
      sweep_addr    <= '0;
      clear_color_q <= '0;
      drop_count    <= '0;
      overflow      <= 1'b0;
    end else begin
      fb_we <= 1'b0;
      if (pop) begin
        fb_addr <= fifo_dout[PW-1:FB_COLOR_W];
        fb_data <= fifo_dout[FB_COLOR_W-1:0];
        fb_we   <= 1'b1;
      end else if (state == ST_CLEAR) begin
        fb_addr <= sweep_addr;
        fb_data <= clear_color_q;
        fb_we   <= 1'b1;
      end

      if (state == ST_DRAIN)      sweep_addr <= '0;
      else if (state == ST_CLEAR) sweep_addr <= sweep_addr + ADDR_W'(1);

      if (state == ST_RUN && clear_start) clear_color_q <= clear_color;

      if (accept && !in_range && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;

      if (pix_we && !pix_ready) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Bench for framebuffer_writer: expected RAM writes are queued when stimulus
// is driven and compared in order as fb_we strobes appear.
module tb_framebuffer_writer;
  import framebuffer_writer_pkg::*;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [8:0]  pix_x = '0;
  logic [7:0]  pix_y = '0;
  logic [11:0] pix_color = '0;
  logic        pix_we = 1'b0;
  logic        pix_ready;
  logic        clear_start = 1'b0;
  logic [11:0] clear_color = '0;
  logic        clear_busy;
  logic        clear_done;
  logic [16:0] fb_addr;
  logic [11:0] fb_data;
  logic        fb_we;
  logic [15:0] drop_count;
  logic        overflow;

  framebuffer_writer dut (
    .clock       (clock),
    .resetn      (resetn),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_color   (pix_color),
    .pix_we      (pix_we),
    .pix_ready   (pix_ready),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_we       (fb_we),
    .drop_count  (drop_count),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  logic [28:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [28:0] exp_word(input int x, input int y, input logic [11:0] c);
    logic [16:0] a;
    a = 17'(y * 320 + x);
    return {a, c};
  endfunction

  task automatic push_exp(input int x, input int y, input logic [11:0] c);
    if (x < 320 && y < 240) exp_q.push_back(exp_word(x, y, c));
  endtask

  task automatic send_pix(input int x, input int y, input logic [11:0] c);
    pix_x = 9'(x);
    pix_y = 8'(y);
    pix_color = c;
    pix_we = 1'b1;
    push_exp(x, y, c);
    tick();
    pix_we = 1'b0;
  endtask

  task automatic push_sweep(input logic [11:0] c);
    for (int a = 0; a < 76800; a++) exp_q.push_back({17'(a), c});
  endtask

  task automatic check_zero_outputs(input string pfx);
    check_val({pfx, "_fb_we"},      32'(fb_we), 0);
    check_val({pfx, "_fb_addr"},    32'(fb_addr), 0);
    check_val({pfx, "_fb_data"},    32'(fb_data), 0);
    check_val({pfx, "_clear_busy"}, 32'(clear_busy), 0);
    check_val({pfx, "_clear_done"}, 32'(clear_done), 0);
    check_val({pfx, "_drop_count"}, 32'(drop_count), 0);
    check_val({pfx, "_overflow"},   32'(overflow), 0);
    check_val({pfx, "_pix_ready"},  32'(pix_ready), 0);
  endtask

  // Scoreboard side: every RAM write must match the head of the queue.
  always @(negedge clock) begin
    logic [28:0] e;
    if (resetn) begin
      if (clear_done) done_cnt++;
      if (clear_busy) check_val("ready_while_busy", 32'(pix_ready), 0);
      if (fb_we) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_write", 32'(fb_we), 0);
        end else begin
          e = exp_q.pop_front();
          check_val("write", 32'({fb_addr, fb_data}), 32'(e));
        end
      end
    end
  end

  initial begin
    bit got;
    int done_base;

    // reset state
    #12;
    check_zero_outputs("rst");
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check_val("ready_after_rst", 32'(pix_ready), 1);

    // 1: single pixel latency
    tick();
    pix_x = 9'd10; pix_y = 8'd2; pix_color = 12'hBBB; pix_we = 1'b1;
    push_exp(10, 2, 12'hBBB);
    tick();
    pix_we = 1'b0;
    @(negedge clock);
    check_val("lat_edge_k", 32'(fb_we), 0);
    @(negedge clock);
    check_val("lat_edge_k1_we", 32'(fb_we), 1);
    check_val("lat_addr", 32'(fb_addr), 650);
    check_val("lat_data", 32'(fb_data), 32'h BBB);
    @(negedge clock);
    check_val("single_we_drop", 32'(fb_we), 0);

    // 2: clipping boundaries
    tick();
    send_pix(319, 239, 12'h123);
    send_pix(320, 0, 12'h456);
    send_pix(0, 240, 12'h789);
    repeat (4) tick();
    check_val("drop_count_clip", 32'(drop_count), 2);
    check_val("q_after_clip", 32'(exp_q.size()), 0);

    // 3: back-to-back stream
    for (int i = 0; i < 6; i++) begin
      pix_x = 9'(i * 37);
      pix_y = 8'(i * 11 + 3);
      pix_color = 12'(12'h100 + i);
      pix_we = 1'b1;
      push_exp(i * 37, i * 11 + 3, 12'(12'h100 + i));
      tick();
    end
    pix_we = 1'b0;
    repeat (4) tick();
    check_val("stream_overflow", 32'(overflow), 0);
    check_val("q_after_stream", 32'(exp_q.size()), 0);

    // 4 + 6: clear with queued pixels, pixel during busy, clear_start during CLEAR
    for (int i = 0; i < 3; i++) begin
      pix_x = 9'(i + 20);
      pix_y = 8'(i + 100);
      pix_color = 12'(12'hA00 + i);
      pix_we = 1'b1;
      push_exp(i + 20, i + 100, 12'(12'hA00 + i));
      if (i == 2) begin
        clear_start = 1'b1;
        clear_color = 12'h5A5;
      end
      tick();
    end
    pix_we = 1'b0;
    clear_start = 1'b0;
    clear_color = 12'h000;
    push_sweep(12'h5A5);
    tick();
    tick();
    @(negedge clock);
    check_val("busy_in_clear", 32'(clear_busy), 1);
    tick();
    pix_x = 9'd7; pix_y = 8'd7; pix_color = 12'hFFF; pix_we = 1'b1;
    tick();
    pix_we = 1'b0;
    tick();
    check_val("overflow_busy", 32'(overflow), 1);
    repeat (100) tick();
    clear_start = 1'b1;
    clear_color = 12'h0F0;
    tick();
    clear_start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 80000 && !got; c++) begin
      @(negedge clock);
      if (clear_done) got = 1'b1;
    end
    check_val("clear_done_seen", 32'(got), 1);
    repeat (5) @(negedge clock);
    check_val("done_count", 32'(done_cnt), 1);
    check_val("q_after_clear", 32'(exp_q.size()), 0);
    check_val("busy_after_clear", 32'(clear_busy), 0);
    check_val("ready_after_clear", 32'(pix_ready), 1);
    check_val("drop_after_clear", 32'(drop_count), 2);

    // 5: reset in the middle of a sweep
    done_base = done_cnt;
    tick();
    clear_start = 1'b1;
    clear_color = 12'hABC;
    tick();
    clear_start = 1'b0;
    push_sweep(12'hABC);
    got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clock);
      if (fb_we && fb_addr == 17'd1000) got = 1'b1;
    end
    check_val("sweep_reached_1000", 32'(got), 1);
    #2;
    resetn = 1'b0;
    #1;
    check_zero_outputs("midrst");
    exp_q.delete();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (20) tick();
    check_val("no_done_after_rst", 32'(done_cnt), 32'(done_base));
    check_val("busy_after_rst", 32'(clear_busy), 0);
    check_val("ready_after_midrst", 32'(pix_ready), 1);
    send_pix(100, 50, 12'h321);
    repeat (4) tick();
    check_val("q_after_rst_pix", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
